// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Sequences a small instruction memory. After reset the controller is in a
//   boot-load phase. Program words arrive on a valid/ready port and are written
//   into consecutive word addresses. The controller then enters the fetch phase.
//   In that phase it owns the PC, drives the memory byte address, and registers
//   each instruction together with its PC for the decode stage. The memory read
//   is combinational from mem_addr_o.
//
//   Optional feature macro: INSTR_FETCH_HALT_EN
//     defined   : advancing onto HALT_WORD stops fetch (HALT state, halt_o=1)
//     undefined : HALT is unreachable and halt_o stays 0
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   boot_skip_i                leave LOAD without writing (memory preloaded)
//   load_valid_i/_data_i/_last_i, load_ready_o   loader handshake
//   stall_i, branch_i, branch_addr_i             fetch control from decode
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  instruction memory port
//   instr_o, pc_o, instr_valid_o                 registered fetch output
//   boot_done_o, halt_o                          phase status
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int          MEM_WORDS = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boot_skip_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        boot_done_o,
  output logic        halt_o
);

  // Counter is one bit wider than the word index so it can express "full".
  localparam int               CNT_W    = $clog2(MEM_WORDS) + 1;
  localparam int               PAD_W    = 32 - CNT_W - 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Byte-address wrap mask: PC and branch targets live modulo MEM_WORDS*4.
  localparam logic [31:0]      PC_MASK  = 32'(MEM_WORDS * 4 - 1);

`ifdef INSTR_FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_instr, w_instr_nxt;
  logic [31:0]      r_pc_out, w_pc_out_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_boot_done, w_boot_done_nxt;
  logic             r_halt, w_halt_nxt;
  logic             w_ready;
  logic             w_xfer;
  logic             w_enter_run;
  logic [31:0]      w_addr;

  // Next-state and combinational memory/loader outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_pc_out_nxt    = r_pc_out;
    w_valid_nxt     = r_valid;
    w_boot_done_nxt = r_boot_done;
    w_halt_nxt      = r_halt;
    w_ready         = 1'b0;
    w_xfer          = 1'b0;
    w_enter_run     = 1'b0;
    w_addr          = r_pc;

    case (r_state)
      ST_LOAD: begin
        w_addr  = {{PAD_W{1'b0}}, r_cnt, 2'b00};
        // A skip cycle never accepts a word, so ready is withheld then.
        w_ready = !rst_i && !boot_skip_i && (r_cnt < CNT_FULL);
        w_xfer  = w_ready && load_valid_i;
        if (w_xfer) begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
          w_enter_run = load_last_i || (r_cnt == CNT_LAST);
        end else begin
          w_enter_run = boot_skip_i;
        end
        if (w_enter_run) begin
          w_state_nxt     = ST_RUN;
          w_pc_nxt        = RESET_PC;
          w_boot_done_nxt = 1'b1;
          w_valid_nxt     = 1'b0;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        w_addr = r_pc;
        if (branch_i) begin
          w_pc_nxt    = branch_addr_i & PC_MASK & 32'hFFFF_FFFC;
          w_valid_nxt = 1'b0;
        end else if (stall_i) begin
          w_pc_nxt = r_pc;
        end else if (HALT_EN && (mem_rdata_i == HALT_WORD)) begin
          // Halt word is swallowed: nothing is presented and the PC freezes.
          w_state_nxt = ST_HALT;
          w_valid_nxt = 1'b0;
          w_halt_nxt  = 1'b1;
        end else begin
          w_instr_nxt  = mem_rdata_i;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
          w_pc_nxt     = (r_pc + 32'd4) & PC_MASK;
        end
      end
      ST_HALT: begin
        w_valid_nxt = 1'b0;
        w_halt_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_LOAD;
      r_cnt       <= {CNT_W{1'b0}};
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0000_0000;
      r_pc_out    <= RESET_PC;
      r_valid     <= 1'b0;
      r_boot_done <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_valid     <= w_valid_nxt;
      r_boot_done <= w_boot_done_nxt;
      r_halt      <= w_halt_nxt;
    end
  end

  assign load_ready_o  = w_ready;
  assign mem_we_o      = w_xfer;
  assign mem_addr_o    = w_addr;
  assign mem_wdata_o   = load_data_i;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_out;
  assign instr_valid_o = r_valid;
  assign boot_done_o   = r_boot_done;
  assign halt_o        = r_halt;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

`ifdef INSTR_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int WORDS = 32;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst, skip, lvalid, llast, stall, branch;
  logic [31:0] ldata, baddr;
  logic        load_ready_o, mem_we_o, instr_valid_o, boot_done_o, halt_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, instr_o, pc_o;

  // memory attached to the DUT, plus a bench-side preload port
  logic [31:0] dut_mem [WORDS];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_data;

  // reference model state
  logic [31:0] exp_mem [WORDS];
  bit          m_boot, m_halt, m_valid;
  int          m_cnt, m_pc, m_pco;
  logic [31:0] m_instr;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .boot_skip_i(skip),
    .load_valid_i(lvalid), .load_data_i(ldata), .load_last_i(llast),
    .load_ready_o(load_ready_o), .stall_i(stall), .branch_i(branch),
    .branch_addr_i(baddr), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .instr_o(instr_o),
    .pc_o(pc_o), .instr_valid_o(instr_valid_o), .boot_done_o(boot_done_o),
    .halt_o(halt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = dut_mem[mem_addr_o[6:2]];

  always @(posedge clk) begin
    if (mem_we_o) dut_mem[mem_addr_o[6:2]] <= mem_wdata_o;
    else if (pre_we) dut_mem[pre_idx] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_W) w = 32'h0000_0000;
    return w;
  endfunction

  // One clock cycle: inputs already driven; checks combinational outputs,
  // advances the reference model at the edge, then checks registered outputs.
  task automatic cyc();
    bit exp_ready, exp_we, enter;
    logic [31:0] w;
    #3;
    exp_ready = !m_boot && !rst && !skip && (m_cnt < WORDS);
    exp_we    = exp_ready && lvalid;
    check("load_ready", {31'd0, load_ready_o}, {31'd0, exp_ready});
    check("mem_we", {31'd0, mem_we_o}, {31'd0, exp_we});
    if (exp_we) begin
      check("wr_addr", mem_addr_o, 32'(m_cnt * 4));
      check("wr_data", mem_wdata_o, ldata);
    end
    if (m_boot && !m_halt && !rst) check("rd_addr", mem_addr_o, 32'(m_pc));
    @(posedge clk);
    enter = 1'b0;
    if (rst) begin
      m_boot = 0; m_halt = 0; m_valid = 0;
      m_cnt = 0; m_pc = 0; m_pco = 0; m_instr = 32'h0;
    end else if (!m_boot) begin
      if (exp_we) begin
        exp_mem[m_cnt] = ldata;
        m_cnt++;
        if (llast || m_cnt == WORDS) enter = 1'b1;
      end else if (skip) begin
        enter = 1'b1;
      end
      if (enter) begin m_boot = 1; m_pc = 0; m_valid = 0; end
    end else if (m_halt) begin
      m_valid = 0;
    end else if (branch) begin
      m_pc = int'(baddr % 32'd128) / 4 * 4;
      m_valid = 0;
    end else if (!stall) begin
      w = exp_mem[m_pc / 4];
      if (HALT_EN && w == HALT_W) begin
        m_halt = 1; m_valid = 0;
      end else begin
        m_instr = w; m_pco = m_pc; m_valid = 1; m_pc = (m_pc + 4) % 128;
      end
    end
    #1;
    check("instr_o", instr_o, m_instr);
    check("pc_o", pc_o, 32'(m_pco));
    check("instr_valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
    check("boot_done", {31'd0, boot_done_o}, {31'd0, m_boot});
    check("halt_o", {31'd0, halt_o}, {31'd0, m_halt});
  endtask

  task automatic idle_inputs();
    skip = 0; lvalid = 0; llast = 0; ldata = 32'h0;
    stall = 0; branch = 0; baddr = 32'h0;
  endtask

  // Preload memory under reset; halt_idx >= 0 plants the halt word there.
  task automatic preload(input int halt_idx);
    idle_inputs();
    rst = 1;
    for (int i = 0; i < WORDS; i++) begin
      pre_we = 1; pre_idx = 5'(i);
      pre_data = (i == halt_idx) ? HALT_W : rnd_word();
      exp_mem[i] = pre_data;
      cyc();
    end
    pre_we = 0;
    cyc();
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    if ($urandom_range(3) == 0) begin lvalid = 0; cyc(); end
    lvalid = 1; ldata = d; llast = last;
    cyc();
    lvalid = 0; llast = 0;
  endtask

  task automatic run_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    pre_we = 0; pre_idx = 5'd0; pre_data = 32'h0;
    m_boot = 0; m_halt = 0; m_valid = 0; m_cnt = 0; m_pc = 0; m_pco = 0; m_instr = 32'h0;
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;

    // 1: load three words with last on the third, then fetch them
    preload(-1);
    rst = 0;
    load_word(rnd_word(), 1'b0);
    load_word(rnd_word(), 1'b0);
    load_word(rnd_word(), 1'b1);
    run_cycles(6);

    // 2: full 32-word load without last; a 33rd word is refused; fetch wraps
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < WORDS; i++) load_word(rnd_word(), 1'b0);
    lvalid = 1; ldata = 32'h1234_5678; cyc(); lvalid = 0;
    run_cycles(36);

    // 3: boot skip, pc walks to 124 and wraps to 0
    rst = 1; cyc(); rst = 0;
    skip = 1; cyc(); skip = 0;
    run_cycles(35);

    // 4: stall two cycles at pc=8, then branch to 0x13 while stalled
    rst = 1; cyc(); rst = 0;
    skip = 1; cyc(); skip = 0;
    run_cycles(2);
    stall = 1; cyc(); cyc();
    branch = 1; baddr = 32'h0000_0013; cyc();
    stall = 0; branch = 0;
    run_cycles(3);

    // 5: reset in the middle of a load, then reload from address 0
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 5; i++) load_word(rnd_word(), 1'b0);
    rst = 1; lvalid = 1; ldata = rnd_word(); cyc(); cyc();
    rst = 0; lvalid = 0;
    load_word(rnd_word(), 1'b0);
    load_word(rnd_word(), 1'b1);
    run_cycles(3);

    // 6: halt word at index 2; stall/branch must not disturb a halt
    preload(2);
    rst = 0;
    skip = 1; cyc(); skip = 0;
    run_cycles(4);
    branch = 1; baddr = 32'h0000_0040; cyc();
    branch = 0; stall = 1; cyc();
    run_cycles(3);

    // randomized traffic including resets, skips, stalls and branches
    rst = 1; cyc();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(99) < 2);
      skip   = ($urandom_range(19) == 0);
      lvalid = $urandom_range(1);
      ldata  = ($urandom_range(9) == 0) ? HALT_W : rnd_word();
      llast  = ($urandom_range(7) == 0);
      stall  = ($urandom_range(9) < 3);
      branch = ($urandom_range(9) == 0);
      baddr  = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
